// File: rtl/bus_grant_arbiter_pkg.sv
// Shared types for the bus/DMA grant arbiter.
// Optional watchdog build macro: GRANT_TIMEOUT_EN.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_BUS = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/beat/grant signal bundle between the requesters and the arbiter.
interface bus_grant_arbiter_if;
    logic bus_req;
    logic dma_req;
    logic bus_enb;
    logic mem_enb;
    logic bus_ack;
    logic dma_ack;
    logic done;
    logic timeout;

    // Arbiter side.
    modport slave (
        input  bus_req, dma_req, bus_enb, mem_enb,
        output bus_ack, dma_ack, done, timeout
    );

    // Requester side.
    modport master (
        output bus_req, dma_req, bus_enb, mem_enb,
        input  bus_ack, dma_ack, done, timeout
    );
endinterface

// File: rtl/bus_arb_wdog.sv
// Grant window counter: counts enabled cycles, flags the cycle that would
// reach ACK_WINDOW. Only instantiated when GRANT_TIMEOUT_EN is defined.
module bus_arb_wdog #(
    parameter int ACK_WINDOW = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int WIN_W = $clog2(ACK_WINDOW + 1);

    logic [WIN_W-1:0] win_cnt_q;

    // Window counter: cleared outside GRANT, advances on each beatless GRANT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else if (clr_i) begin
            win_cnt_q <= '0;
        end else if (en_i) begin
            win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (win_cnt_q == WIN_W'(ACK_WINDOW - 1));
endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin grant between bus master and DMA with fixed-length burst
// tracking. Define GRANT_TIMEOUT_EN to enable the first-beat watchdog.
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int ACK_WINDOW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_grant_arbiter_if.slave   bus
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    state_e            state_q,   state_d;
    owner_e            owner_q,   owner_d;
    owner_e            last_q,    last_d;
    logic [BEAT_W-1:0] beat_q,    beat_d;
    logic              bus_ack_q, bus_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              done_q,    done_d;
    logic              timeout_q, timeout_d;

    logic owner_req;
    logic owner_beat;
    logic expire;

    // Only the current owner's request and beat strobe matter once granted.
    assign owner_req  = (owner_q == OWN_BUS) ? bus.bus_req : bus.dma_req;
    assign owner_beat = (owner_q == OWN_BUS) ? bus.bus_enb : bus.mem_enb;

`ifdef GRANT_TIMEOUT_EN
    logic wdog_clr;
    logic wdog_en;

    assign wdog_clr = (state_q != GRANT);
    assign wdog_en  = (state_q == GRANT) && !owner_beat;

    bus_arb_wdog #(
        .ACK_WINDOW (ACK_WINDOW)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // State, ownership, beat counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_BUS;
            last_q    <= OWN_DMA;
            beat_q    <= '0;
            bus_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            bus_ack_q <= bus_ack_d;
            dma_ack_q <= dma_ack_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: arbitration, burst progress, abandonment and watchdog exit.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        beat_d    = beat_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (bus.bus_req && bus.dma_req) begin
                    owner_d = (last_q == OWN_BUS) ? OWN_DMA : OWN_BUS;
                    state_d = GRANT;
                end else if (bus.bus_req) begin
                    owner_d = OWN_BUS;
                    state_d = GRANT;
                end else if (bus.dma_req) begin
                    owner_d = OWN_DMA;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A beat outranks both a dropped request and watchdog expiry.
                if (owner_beat) begin
                    beat_d  = BEAT_W'(1);
                    state_d = (BURST_LEN == 1) ? DONE : XFER;
                end else if (!owner_req) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (expire) begin
                    last_d    = owner_q;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            XFER: begin
                if (owner_beat) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                beat_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Acks follow the next state so they are asserted the cycle after grant.
    assign bus_ack_d = ((state_d == GRANT) || (state_d == XFER)) && (owner_d == OWN_BUS);
    assign dma_ack_d = ((state_d == GRANT) || (state_d == XFER)) && (owner_d == OWN_DMA);
    assign done_d    = (state_d == DONE);

    assign bus.bus_ack = bus_ack_q;
    assign bus.dma_ack = dma_ack_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Randomized scoreboard bench for bus_grant_arbiter (honours GRANT_TIMEOUT_EN).
module tb_bus_grant_arbiter;
    localparam int BURST_LEN  = 4;
    localparam int ACK_WINDOW = 5;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_grant_arbiter_if arb_if ();

    bus_grant_arbiter #(
        .BURST_LEN  (BURST_LEN),
        .ACK_WINDOW (ACK_WINDOW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (arb_if.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int cycle_no   = 0;

    // Expected {bus_ack, dma_ack, done, timeout} for each driven cycle.
    logic [3:0] exp_q[$];

    // Reference model: who holds the grant (-1 none, 0 bus, 1 dma),
    // how many beats it has delivered, how long it has waited for the first.
    int  m_owner;
    int  m_last;
    int  m_beats;
    int  m_waited;
    bit  m_done;

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_beats  = 0;
        m_waited = 0;
        m_done   = 1'b0;
    endtask

    // Advance the model by one clock edge and return the outputs seen after it.
    function automatic logic [3:0] model_step(input logic b, d, be, me);
        bit to_pulse;
        bit beat;
        bit req_o;
        to_pulse = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_owner < 0) begin
            if (b && d)  m_owner = (m_last == 0) ? 1 : 0;
            else if (b)  m_owner = 0;
            else if (d)  m_owner = 1;
            m_beats  = 0;
            m_waited = 0;
        end else begin
            beat  = (m_owner == 0) ? be : me;
            req_o = (m_owner == 0) ? b : d;
            if (beat) begin
                m_beats++;
                if (m_beats == BURST_LEN) begin
                    m_done  = 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (m_beats == 0) begin
                if (!req_o) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (TO_EN) begin
                    m_waited++;
                    if (m_waited == ACK_WINDOW) begin
                        to_pulse = 1'b1;
                        m_last   = m_owner;
                        m_owner  = -1;
                    end
                end
            end
        end
        return {m_owner == 0, m_owner == 1, m_done, to_pulse};
    endfunction

    // Drive one cycle of stimulus and queue its expected response.
    task automatic cyc(input logic b, d, be, me);
        @(negedge clk);
        arb_if.bus_req = b;
        arb_if.dma_req = d;
        arb_if.bus_enb = be;
        arb_if.mem_enb = me;
        exp_q.push_back(model_step(b, d, be, me));
    endtask

    task automatic idle_inputs();
        arb_if.bus_req = 1'b0;
        arb_if.dma_req = 1'b0;
        arb_if.bus_enb = 1'b0;
        arb_if.mem_enb = 1'b0;
    endtask

    // Assert reset between edges; outputs must clear without a clock.
    task automatic apply_reset(input string tag);
        logic [3:0] got;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {arb_if.bus_ack, arb_if.dma_ack, arb_if.done, arb_if.timeout};
        compared++;
        if (got !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_%s got=%b required=0000", tag, got);
        end else begin
            $display("ok   reset_%s outputs=%b", tag, got);
        end
        exp_q.delete();
        model_reset();
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one queued expectation consumed per clock, checked after the edge.
    initial begin
        logic [3:0] got;
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (rst_n && exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {arb_if.bus_ack, arb_if.dma_ack, arb_if.done, arb_if.timeout};
                compared++;
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL cyc%0d outputs got=%b required=%b (bus_ack,dma_ack,done,timeout)",
                             cycle_no, got, e);
                end else begin
                    $display("ok   cyc%0d outputs=%b", cycle_no, got);
                end
            end
        end
    end

    // Safety net in case the stimulus never completes.
    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached=1 required=0");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        model_reset();
        apply_reset("initial");

        // Single bus burst: beats on the second through fifth granted cycles.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(1, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Both requesting with continuous beats: grants must alternate.
        repeat (24) cyc(1, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0);

        // DMA owner with bus_enb noise; only mem_enb advances the burst.
        repeat (4) cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);

        // Long beatless grant (times out with the watchdog, held without).
        repeat (25) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // First beat landing on the would-be expiry edge.
        repeat (5) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Request dropped before any beat.
        repeat (3) cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);

        // Reset in the middle of a burst, then a fresh grant.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        apply_reset("mid_xfer");
        cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);

        // Randomized traffic with phases of varying beat density.
        for (int ph = 0; ph < 40; ph++) begin
            int beat_pct;
            beat_pct = (ph % 4 == 0) ? 0 : int'($urandom_range(10, 90));
            for (int k = 0; k < 40; k++) begin
                cyc(($urandom_range(0, 99) < 70),
                    ($urandom_range(0, 99) < 60),
                    ($urandom_range(0, 99) < beat_pct),
                    ($urandom_range(0, 99) < beat_pct));
            end
        end

        cyc(0, 0, 0, 0);
        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
